imem_fetch_unit: RTL and testbench

- Parametrised instruction memory with a program-load port and a multi-word fetch engine.
- Replaces the fixed 8-bit, 256-entry, negedge-read instruction store.
- Sits between the PC/control unit and the instruction decoder.
- Assembles 1..FETCH_WORDS consecutive words into one instruction, with a request/valid handshake, address wrap-around and load/fetch arbitration.

---
 rtl/imem_pkg.sv | 22 ++
 rtl/imem_ram.sv | 52 +++++
 rtl/imem_fetch_unit.sv | 166 ++++++++++++++++
 tb/tb_imem_fetch_unit.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared types and helpers for the instruction memory fetch unit.
// Optional parity column is enabled with IMEM_PARITY_EN.
package imem_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StStall,
    StDone
  } fetch_state_e;

  // Widest word the parity helper and the NOP constant cover.
  localparam int unsigned ParityMaxW = 64;

  localparam logic [ParityMaxW-1:0] NopWord = '0;

  // Even parity: the stored bit makes the total count of ones even.
  function automatic logic even_parity(input logic [ParityMaxW-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/imem_ram.sv
// Single-port synchronous RAM; a load always wins the port over a read.
// IMEM_PARITY_EN adds a parity column checked on every read.
module imem_ram
  import imem_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 256
) (
  input  logic              clock,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_perr
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              wr_ok;
  logic              rd_ok;

  // Out-of-range writes are dropped rather than aliased.
  assign wr_ok = load_en && (32'(load_addr) < DEPTH);
  assign rd_ok = !load_en && rd_en && (32'(rd_addr) < DEPTH);

  always_ff @(posedge clock) begin
    if (wr_ok) begin
      mem_q[load_addr] <= load_data;
    end
    if (rd_ok) begin
      rd_data <= mem_q[rd_addr];
    end
  end

`ifdef IMEM_PARITY_EN
  logic par_q [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_ok) begin
      par_q[load_addr] <= even_parity(ParityMaxW'(load_data));
    end
    if (rd_ok) begin
      rd_perr <= par_q[rd_addr] ^ even_parity(ParityMaxW'(mem_q[rd_addr]));
    end
  end
`else
  assign rd_perr = 1'b0;
`endif

endmodule

// File: rtl/imem_fetch_unit.sv
// Instruction memory with program-load port and multi-word fetch engine.
// Define IMEM_PARITY_EN to store and check a parity bit per word.
module imem_fetch_unit
  import imem_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned FETCH_WORDS = 2,
  parameter int unsigned LEN_W       = 2
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          load_en,
  input  logic [ADDR_W-1:0]             load_addr,
  input  logic [DATA_W-1:0]             load_data,
  input  logic                          fetch_req,
  input  logic [ADDR_W-1:0]             fetch_addr,
  input  logic [LEN_W-1:0]              fetch_len,
  output logic                          fetch_ready,
  output logic [DATA_W*FETCH_WORDS-1:0] instr_out,
  output logic                          instr_valid,
  output logic                          fetch_fault
);

  localparam int unsigned SumW = ADDR_W + 1;

  fetch_state_e state_q, state_d;

  logic [ADDR_W-1:0]             base_q, base_d;
  logic [LEN_W-1:0]              len_q, len_d;
  logic [LEN_W-1:0]              k_q, k_d;
  logic [LEN_W-1:0]              pend_slot_q, pend_slot_d;
  logic                          pend_q, pend_d;
  logic                          pend_oor_q, pend_oor_d;
  logic [DATA_W*FETCH_WORDS-1:0] asm_q, asm_d;
  logic                          fault_q, fault_d;

  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_perr;

  logic [SumW-1:0] raw_addr;
  logic [SumW-1:0] wrap_addr;
  logic            base_oor;
  logic            issue;
  logic            len_ok;
  logic            last_cap;

  // A base at or above DEPTH never wraps; every slot of that fetch reads as NOP.
  assign raw_addr  = {1'b0, base_q} + SumW'(k_q);
  assign base_oor  = {1'b0, base_q} >= SumW'(DEPTH);
  assign wrap_addr = (raw_addr >= SumW'(DEPTH)) ? raw_addr - SumW'(DEPTH) : raw_addr;

  assign len_ok   = (fetch_len != '0) && (32'(fetch_len) <= FETCH_WORDS);
  assign issue    = (state_q inside {StRead, StStall}) && !load_en && (k_q < len_q);
  assign rd_en    = issue && !base_oor;
  assign rd_addr  = wrap_addr[ADDR_W-1:0];
  assign last_cap = pend_q && (pend_slot_q == len_q - LEN_W'(1));

  imem_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clock     (clock),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_perr   (rd_perr)
  );

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    len_d       = len_q;
    k_d         = k_q;
    pend_d      = 1'b0;
    pend_slot_d = k_q;
    pend_oor_d  = 1'b0;
    asm_d       = asm_q;
    fault_d     = fault_q;

    unique case (state_q)
      StIdle: begin
        if (fetch_req) begin
          asm_d = '0;
          k_d   = '0;
          if (len_ok) begin
            base_d  = fetch_addr;
            len_d   = fetch_len;
            fault_d = 1'b0;
            state_d = StRead;
          end else begin
            fault_d = 1'b1;
            state_d = StDone;
          end
        end
      end

      // A read issued before a stall still lands; the RAM holds rd_data meanwhile.
      StRead, StStall: begin
        if (pend_q) begin
          for (int i = 0; i < FETCH_WORDS; i++) begin
            if (pend_slot_q == LEN_W'(i)) begin
              asm_d[i*DATA_W +: DATA_W] = pend_oor_q ? NopWord[DATA_W-1:0] : rd_data;
            end
          end
          if (pend_oor_q || rd_perr) begin
            fault_d = 1'b1;
          end
        end
        if (issue) begin
          pend_d     = 1'b1;
          pend_oor_d = base_oor;
          k_d        = k_q + LEN_W'(1);
        end
        if (last_cap) begin
          state_d = StDone;
        end else if (load_en) begin
          state_d = StStall;
        end else begin
          state_d = StRead;
        end
      end

      StDone: state_d = StIdle;

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      base_q      <= '0;
      len_q       <= '0;
      k_q         <= '0;
      pend_q      <= 1'b0;
      pend_slot_q <= '0;
      pend_oor_q  <= 1'b0;
      asm_q       <= '0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      len_q       <= len_d;
      k_q         <= k_d;
      pend_q      <= pend_d;
      pend_slot_q <= pend_slot_d;
      pend_oor_q  <= pend_oor_d;
      asm_q       <= asm_d;
      fault_q     <= fault_d;
    end
  end

  assign fetch_ready = (state_q == StIdle);
  assign instr_valid = (state_q == StDone);
  assign instr_out   = asm_q;
  assign fetch_fault = fault_q;

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Directed bench for imem_fetch_unit: a DEPTH=256 and a DEPTH=200 instance.
// Parity corruption sequence runs only when IMEM_PARITY_EN is defined.
module tb_imem_fetch_unit;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic       load_en;
  logic [7:0] load_addr;
  logic [7:0] load_data;
  logic       fetch_req;
  logic [7:0] fetch_addr;
  logic [1:0] fetch_len;

  logic        ready_a, valid_a, fault_a;
  logic [15:0] instr_a;
  logic        ready_s, valid_s, fault_s;
  logic [15:0] instr_s;

  int   checks   = 0;
  int   failures = 0;
  logic sel      = 1'b0;

  imem_fetch_unit dut_a (
    .clock       (clock),
    .reset       (reset),
    .load_en     (load_en),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_len   (fetch_len),
    .fetch_ready (ready_a),
    .instr_out   (instr_a),
    .instr_valid (valid_a),
    .fetch_fault (fault_a)
  );

  imem_fetch_unit #(
    .DATA_W      (8),
    .ADDR_W      (8),
    .DEPTH       (200),
    .FETCH_WORDS (2),
    .LEN_W       (2)
  ) dut_s (
    .clock       (clock),
    .reset       (reset),
    .load_en     (load_en),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_len   (fetch_len),
    .fetch_ready (ready_s),
    .instr_out   (instr_s),
    .instr_valid (valid_s),
    .fetch_fault (fault_s)
  );

  typedef struct {
    logic        sel;
    logic [7:0]  addr;
    logic [1:0]  len;
    logic [15:0] instr;
    logic        fault;
    int          lat;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_load(input logic [7:0] a, input logic [7:0] d);
    @(negedge clock);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    @(negedge clock);
    load_en   = 1'b0;
  endtask

  // Latency = rising edges after the accepting edge until instr_valid is seen.
  task automatic wait_valid(output logic [15:0] instr, output logic fault, output int lat);
    lat = 0;
    while (!(sel ? valid_s : valid_a) && lat < 20) begin
      @(posedge clock);
      #1;
      lat++;
    end
    instr = sel ? instr_s : instr_a;
    fault = sel ? fault_s : fault_a;
  endtask

  task automatic do_fetch(input logic [7:0] a, input logic [1:0] l,
                          output logic [15:0] instr, output logic fault, output int lat);
    int guard;
    guard = 0;
    @(negedge clock);
    while (!(sel ? ready_s : ready_a) && guard < 20) begin
      @(negedge clock);
      guard++;
    end
    fetch_req  = 1'b1;
    fetch_addr = a;
    fetch_len  = l;
    @(posedge clock);
    #1;
    fetch_req = 1'b0;
    wait_valid(instr, fault, lat);
  endtask

  logic [15:0] got_instr;
  logic        got_fault;
  int          got_lat;

  initial begin
    vecs[0]  = '{1'b0, 8'h00, 2'd2, 16'h0200, 1'b0, 3};
    vecs[1]  = '{1'b0, 8'h02, 2'd2, 16'h0C20, 1'b0, 3};
    vecs[2]  = '{1'b0, 8'h03, 2'd1, 16'h000C, 1'b0, 2};
    vecs[3]  = '{1'b0, 8'hFF, 2'd2, 16'h00C1, 1'b0, 3};
    vecs[4]  = '{1'b0, 8'h00, 2'd0, 16'h0000, 1'b1, 0};
    vecs[5]  = '{1'b0, 8'h01, 2'd2, 16'h2002, 1'b0, 3};
    vecs[6]  = '{1'b0, 8'h00, 2'd3, 16'h0000, 1'b1, 0};
    vecs[7]  = '{1'b1, 8'd199, 2'd2, 16'h0011, 1'b0, 3};
    vecs[8]  = '{1'b1, 8'd210, 2'd1, 16'h0000, 1'b1, 2};
    vecs[9]  = '{1'b1, 8'h03, 2'd2, 16'h440C, 1'b0, 3};
    vecs[10] = '{1'b1, 8'hFF, 2'd2, 16'h0000, 1'b1, 3};

    reset      = 1'b1;
    load_en    = 1'b0;
    load_addr  = '0;
    load_data  = '0;
    fetch_req  = 1'b0;
    fetch_addr = '0;
    fetch_len  = '0;
    repeat (2) @(negedge clock);
    check("reset_ready", 32'(ready_a), 32'd1);
    check("reset_valid", 32'(valid_a), 32'd0);
    check("reset_instr", 32'(instr_a), 32'd0);
    check("reset_fault", 32'(fault_a), 32'd0);
    reset = 1'b0;

    do_load(8'h00, 8'h00);
    do_load(8'h01, 8'h02);
    do_load(8'h02, 8'h20);
    do_load(8'h03, 8'h0C);
    do_load(8'h04, 8'h44);
    do_load(8'hFF, 8'hC1);
    do_load(8'd199, 8'h11);
    do_load(8'h10, 8'h31);
    do_load(8'h11, 8'h99);

    for (int i = 0; i < 11; i++) begin
      sel = vecs[i].sel;
      do_fetch(vecs[i].addr, vecs[i].len, got_instr, got_fault, got_lat);
      check($sformatf("v%0d_instr", i), 32'(got_instr), 32'(vecs[i].instr));
      check($sformatf("v%0d_fault", i), 32'(got_fault), 32'(vecs[i].fault));
      check($sformatf("v%0d_latency", i), 32'(got_lat), 32'(vecs[i].lat));
      @(posedge clock);
      #1;
      check($sformatf("v%0d_valid_pulse", i), 32'(sel ? valid_s : valid_a), 32'd0);
      check($sformatf("v%0d_instr_hold", i), 32'(sel ? instr_s : instr_a), 32'(vecs[i].instr));
      check($sformatf("v%0d_ready_after", i), 32'(sel ? ready_s : ready_a), 32'd1);
    end

    // Loads for two cycles right after accept stall the fetch; word 1 sees the new value.
    sel = 1'b0;
    @(negedge clock);
    fetch_req  = 1'b1;
    fetch_addr = 8'h10;
    fetch_len  = 2'd2;
    @(posedge clock);
    #1;
    fetch_req = 1'b0;
    load_en   = 1'b1;
    load_addr = 8'h11;
    load_data = 8'h55;
    @(posedge clock);
    #1;
    check("stall_ready_low", 32'(ready_a), 32'd0);
    @(posedge clock);
    #1;
    load_en = 1'b0;
    wait_valid(got_instr, got_fault, got_lat);
    check("stall_instr", 32'(got_instr), 32'h5531);
    check("stall_fault", 32'(got_fault), 32'd0);
    check("stall_latency", 32'(got_lat + 2), 32'd5);

    // Load and fetch in the same IDLE cycle: the fetch observes the fresh word.
    @(posedge clock);
    @(negedge clock);
    load_en    = 1'b1;
    load_addr  = 8'h20;
    load_data  = 8'h77;
    fetch_req  = 1'b1;
    fetch_addr = 8'h20;
    fetch_len  = 2'd1;
    @(posedge clock);
    #1;
    load_en   = 1'b0;
    fetch_req = 1'b0;
    wait_valid(got_instr, got_fault, got_lat);
    check("idle_load_instr", 32'(got_instr), 32'h0077);
    check("idle_load_latency", 32'(got_lat), 32'd2);

`ifdef IMEM_PARITY_EN
    do_load(8'h05, 8'h3C);
    @(negedge clock);
    dut_a.u_ram.mem_q[5] = dut_a.u_ram.mem_q[5] ^ 8'h01;
    do_fetch(8'h05, 2'd1, got_instr, got_fault, got_lat);
    check("parity_instr", 32'(got_instr), 32'h003D);
    check("parity_fault", 32'(got_fault), 32'd1);
`endif

    // Reset mid-READ, after slot 0 has been captured.
    @(posedge clock);
    @(negedge clock);
    fetch_req  = 1'b1;
    fetch_addr = 8'h02;
    fetch_len  = 2'd2;
    @(posedge clock);
    #1;
    fetch_req = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1;
    check("midfetch_partial", 32'(instr_a), 32'h0020);
    #1;
    reset = 1'b1;
    #1;
    check("midreset_ready", 32'(ready_a), 32'd1);
    check("midreset_valid", 32'(valid_a), 32'd0);
    check("midreset_instr", 32'(instr_a), 32'd0);
    check("midreset_fault", 32'(fault_a), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    do_fetch(8'h00, 2'd2, got_instr, got_fault, got_lat);
    check("retained_instr", 32'(got_instr), 32'h0200);
    check("retained_latency", 32'(got_lat), 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
